// File: rtl/key_schedule_nr.sv
// key_schedule_nr: collects or expands ROUND round keys and presents them as one registered bus
module key_schedule_nr #(
  parameter int ROUND    = 5,
  parameter int KEY_SIZE = 128,
  parameter int ROT      = 13
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         mode,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [KEY_SIZE-1:0]          s_tdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ROUND*KEY_SIZE-1:0]    round_keys,
  output logic                         busy
);
  localparam int CW = $clog2(ROUND) + 1;
  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, COMMIT, HOLD} state_t;
  state_t                    r_state, w_next;
  logic [CW-1:0]             r_cnt;
  logic [KEY_SIZE-1:0]       r_k [ROUND];
  logic [KEY_SIZE-1:0]       w_prev, w_wdata;
  logic [ROUND*KEY_SIZE-1:0] w_flat;
  logic                      w_beat, w_we, w_last;
  assign s_tready = r_state == IDLE || r_state == LOAD;
  assign busy     = r_state != IDLE;
  assign w_beat   = s_tvalid & s_tready;
  assign w_last   = r_cnt == CW'(ROUND - 1);
  assign w_we     = w_beat || r_state == EXPAND;
  // rotate-left of the previous key, salted with its own index
  assign w_wdata  = r_state == EXPAND
                    ? ({w_prev[KEY_SIZE-ROT-1:0], w_prev[KEY_SIZE-1:KEY_SIZE-ROT]} ^ KEY_SIZE'(r_cnt))
                    : s_tdata;
  always_comb begin
    w_next = r_state;
    w_prev = '0;
    w_flat = '0;
    for (int i = 1; i < ROUND; i++)
      if (r_cnt == CW'(i)) w_prev = r_k[i-1];
    for (int i = 0; i < ROUND; i++)
      w_flat[i*KEY_SIZE +: KEY_SIZE] = r_k[i];
    case (r_state)
      IDLE:    w_next = w_beat ? (mode ? EXPAND : LOAD) : IDLE;
      LOAD:    w_next = (w_beat && w_last) ? COMMIT : LOAD;
      EXPAND:  w_next = w_last ? COMMIT : EXPAND;
      COMMIT:  w_next = HOLD;
      HOLD:    w_next = m_ready ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_k        <= '{default: '0};
      round_keys <= '0;
      m_valid    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_we) begin
        for (int i = 0; i < ROUND; i++)
          if (r_cnt == CW'(i)) r_k[i] <= w_wdata;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == COMMIT) begin
        round_keys <= w_flat;
        m_valid    <= 1'b1;
        r_cnt      <= '0;
      end
      if (r_state == HOLD && m_ready) m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_schedule_nr.sv
// tb_key_schedule_nr: randomized bench for key_schedule_nr against a key-list reference model
module tb_key_schedule_nr;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic rst_n, clr;
  logic md, sv, sr, mv, mr, busy;
  logic [127:0] sd;
  logic [639:0] rk;
  logic b_md, b_sv, b_sr, b_mv, b_mr, b_busy;
  logic [15:0] b_sd;
  logic [31:0] b_rk;
  logic [127:0] mk [5];
  key_schedule_nr #(.ROUND(5), .KEY_SIZE(128), .ROT(13)) dut (
    .clk(clk), .reset_n(rst_n), .clear(clr), .mode(md), .s_tvalid(sv), .s_tready(sr),
    .s_tdata(sd), .m_valid(mv), .m_ready(mr), .round_keys(rk), .busy(busy));
  key_schedule_nr #(.ROUND(2), .KEY_SIZE(16), .ROT(13)) dut_b (
    .clk(clk), .reset_n(rst_n), .clear(clr), .mode(b_md), .s_tvalid(b_sv), .s_tready(b_sr),
    .s_tdata(b_sd), .m_valid(b_mv), .m_ready(b_mr), .round_keys(b_rk), .busy(b_busy));
  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // next key = (prev rotated left by r within ks bits) xor index
  function automatic logic [127:0] step(input logic [127:0] x, input int ks, input int r, input int i);
    logic [127:0] m;
    m = (ks == 128) ? '1 : ((128'd1 << ks) - 128'd1);
    return (((x << r) | (x >> (ks - r))) & m) ^ 128'(i);
  endfunction
  function automatic logic [639:0] flat();
    logic [639:0] f;
    for (int i = 0; i < 5; i++) f[i*128 +: 128] = mk[i];
    return f;
  endfunction
  task automatic load_set(input int gmax);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(gmax, 0)) begin
        sv = 1'b0;
        tick();
        check("gap_busy", busy, i > 0);
        check("gap_valid", mv, 1'b0);
      end
      sv = 1'b1;
      sd = mk[i];
      md = (i == 0) ? 1'b0 : 1'($urandom);
      check("load_tready", sr, 1'b1);
      tick();
    end
    sv = 1'b0;
    md = 1'b0;
    check("commit_tready", sr, 1'b0);
    check("commit_valid", mv, 1'b0);
    tick();
    check("load_valid", mv, 1'b1);
    check("load_keys", rk, flat());
  endtask
  task automatic expand_set(input logic [127:0] master);
    mk[0] = master;
    for (int i = 1; i < 5; i++) mk[i] = step(mk[i-1], 128, 13, i);
    md = 1'b1;
    sv = 1'b1;
    sd = master;
    tick();
    sv = 1'b0;
    md = 1'b0;
    for (int j = 1; j < 5; j++) begin
      check("exp_tready", sr, 1'b0);
      check("exp_valid", mv, 1'b0);
      check("exp_busy", busy, 1'b1);
      tick();
    end
    check("exp_commit_valid", mv, 1'b0);
    tick();
    check("exp_valid_rise", mv, 1'b1);
    check("exp_keys", rk, flat());
  endtask
  task automatic handshake();
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("hs_valid", mv, 1'b0);
    check("hs_busy", busy, 1'b0);
  endtask
  initial begin
    logic [639:0] held;
    logic [127:0] x, k;
    logic [15:0] bk0, bk1, bm;
    rst_n = 1'b0; clr = 1'b0; md = 1'b0; sv = 1'b0; mr = 1'b0; sd = '0;
    b_md = 1'b0; b_sv = 1'b0; b_mr = 1'b0; b_sd = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", mv, 1'b0);
    check("rst_keys", rk, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tready", sr, 1'b1);
    for (int i = 0; i < 5; i++) mk[i] = 128'(i + 1);
    load_set(0);
    handshake();
    repeat (3) begin
      for (int i = 0; i < 5; i++) mk[i] = rnd128();
      load_set(3);
      handshake();
    end
    expand_set(128'h1);
    k = rk[255:128];
    check("exp_k1", k, 128'h2001);
    k = rk[383:256];
    check("exp_k2", k, 128'h4002002);
    handshake();
    repeat (3) begin
      expand_set(rnd128());
      handshake();
    end
    for (int i = 0; i < 5; i++) mk[i] = rnd128();
    load_set(1);
    held = rk;
    x = rnd128();
    sv = 1'b1;
    sd = x;
    repeat (10) begin
      tick();
      check("bp_valid", mv, 1'b1);
      check("bp_keys", rk, held);
      check("bp_tready", sr, 1'b0);
    end
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("bp_hs_valid", mv, 1'b0);
    check("bp_hs_busy", busy, 1'b0);
    check("bp_hs_tready", sr, 1'b1);
    tick();
    check("bp_accept_busy", busy, 1'b1);
    mk[0] = x;
    for (int i = 1; i < 5; i++) begin
      mk[i] = rnd128();
      sd = mk[i];
      tick();
    end
    sv = 1'b0;
    tick();
    check("bp_new_valid", mv, 1'b1);
    check("bp_new_keys", rk, flat());
    handshake();
    for (int i = 0; i < 3; i++) begin
      sv = 1'b1;
      sd = rnd128();
      tick();
    end
    sv = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", busy, 1'b0);
    check("clr_valid", mv, 1'b0);
    check("clr_keys", rk, '0);
    for (int i = 0; i < 5; i++) mk[i] = rnd128();
    load_set(0);
    handshake();
    md = 1'b1;
    sv = 1'b1;
    sd = rnd128();
    tick();
    sv = 1'b0;
    md = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstx_valid", mv, 1'b0);
    check("rstx_keys", rk, '0);
    check("rstx_busy", busy, 1'b0);
    repeat (8) begin
      tick();
      check("rstx_no_valid", mv, 1'b0);
    end
    bk0 = 16'($urandom);
    bk1 = 16'($urandom);
    b_sv = 1'b1;
    b_sd = bk0;
    tick();
    check("b_load_busy", b_busy, 1'b1);
    b_sd = bk1;
    tick();
    b_sv = 1'b0;
    check("b_load_commit", b_mv, 1'b0);
    tick();
    check("b_load_valid", b_mv, 1'b1);
    check("b_load_keys", b_rk, {bk1, bk0});
    b_mr = 1'b1;
    tick();
    b_mr = 1'b0;
    check("b_hs_valid", b_mv, 1'b0);
    bm = 16'($urandom);
    x = step(128'(bm), 16, 13, 1);
    bk1 = x[15:0];
    b_md = 1'b1;
    b_sv = 1'b1;
    b_sd = bm;
    tick();
    b_sv = 1'b0;
    b_md = 1'b0;
    check("b_exp_tready", b_sr, 1'b0);
    check("b_exp_valid0", b_mv, 1'b0);
    tick();
    check("b_exp_commit", b_mv, 1'b0);
    tick();
    check("b_exp_valid", b_mv, 1'b1);
    check("b_exp_keys", b_rk, {bk1, bm});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
